// File: rtl/rr_arbiter_4_if.sv
// rtl/rr_arbiter_4_if.sv - request/grant bundle between requesters and rr_arbiter_4
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    // Requester side drives req/rel and observes the grant.
    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    // Arbiter side samples req/rel and drives the grant.
    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with release and bounded hold time
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_4_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Hold counter is 8 bits wide, so the limit is truncated to that width.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q,  state_nxt;
    logic [3:0] gnt_q,    gnt_nxt;
    logic [1:0] id_q,     id_nxt;
    logic [1:0] ptr_q,    ptr_nxt;
    logic [7:0] hold_q,   hold_nxt;
    logic       to_q,     to_nxt;

    logic [1:0] pick_id;
    logic       pick_valid;
    logic       owner_done;
    logic       hold_expired;

    // Search order ptr, ptr+1, ptr+2, ptr+3; scanning backwards leaves the closest hit.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_id    = ptr_q + 2'(k);
            end
        end
    end

    // Owner gives up the resource by strobing rel or by dropping its request.
    always_comb begin
        owner_done   = bus.rel[id_q] | ~bus.req[id_q];
        hold_expired = (hold_q == HOLD_LIMIT);
    end

    // Next-state and next-output decision for the grant FSM.
    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        ptr_nxt   = ptr_q;
        hold_nxt  = hold_q;
        to_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = OWNED;
                    gnt_nxt   = 4'b0001 << pick_id;
                    id_nxt    = pick_id;
                    ptr_nxt   = pick_id + 2'd1;
                    hold_nxt  = 8'd1;
                end
            end
            OWNED: begin
                if (owner_done) begin
                    // A release that coincides with the hold limit is a normal release.
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    hold_nxt  = 8'd0;
                end else if (hold_expired) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    hold_nxt  = 8'd0;
                    to_nxt    = 1'b1;
                end else begin
                    hold_nxt  = hold_q + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    // State register; reset clears the grant and pointer without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
            id_q    <= id_nxt;
            ptr_q   <= ptr_nxt;
            hold_q  <= hold_nxt;
            to_q    <= to_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - randomized and directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

    localparam int MAXH = 4;

    logic clk;
    logic reset;

    rr_arbiter_4_if ifc ();

    rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: owner index (-1 = nobody), rotating start point, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_id;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_id    = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic [3:0] l);
        bit found;
        if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_id    = idx;
                    m_ptr   = (idx + 1) % 4;
                    m_hold  = 1;
                end
            end
        end else begin
            if (l[m_owner] || !r[m_owner]) begin
                m_owner = -1;
                m_to    = 1'b0;
            end else if (m_hold == MAXH) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end
    endfunction

    task automatic compare_all(input string where);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check({where, ".gnt"},     32'(ifc.gnt),     32'(eg));
        check({where, ".gnt_id"},  32'(ifc.gnt_id),  32'(m_id));
        check({where, ".busy"},    32'(ifc.busy),    32'(m_owner >= 0));
        check({where, ".timeout"}, 32'(ifc.timeout), 32'(m_to));
    endtask

    // Drive inputs for one cycle, advance the model by the edge, check after the edge.
    task automatic step(input string where, input logic [3:0] r, input logic [3:0] l);
        ifc.req = r;
        ifc.rel = l;
        model_edge(r, l);
        @(posedge clk);
        #1;
        compare_all(where);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string where);
        ifc.req = 4'b0000;
        ifc.rel = 4'b0000;
        #1;
        reset = 1'b0;
        #2;
        model_reset();
        compare_all(where);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] l;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        ifc.req  = 4'b0000;
        ifc.rel  = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        reset = 1'b1;
        repeat (3) step("idle_after_por", 4'b0000, 4'b0000);

        // Single requester, release on the third grant cycle.
        step("single.g1", 4'b0100, 4'b0000);
        check("single.id", 32'(ifc.gnt_id), 32'd2);
        step("single.g2", 4'b0100, 4'b0000);
        step("single.g3", 4'b0100, 4'b0000);
        step("single.rel", 4'b0100, 4'b0100);
        check("single.gap", 32'(ifc.gnt), 32'd0);
        step("single.regrant", 4'b0100, 4'b0000);
        check("single.regrant_gnt", 32'(ifc.gnt), 32'h4);

        // Asynchronous reset while owned.
        do_reset("reset_owned");
        repeat (2) step("reset_release", 4'b0000, 4'b0000);

        // Full contention: order 0,1,2,3,0,1 with a gap between grants.
        for (int i = 0; i < 6; i++) begin
            step("rr.grant", 4'b1111, 4'b0000);
            check("rr.order", 32'(ifc.gnt_id), 32'(i % 4));
            step("rr.rel", 4'b1111, 4'(1 << (i % 4)));
            check("rr.gap", 32'(ifc.gnt), 32'd0);
        end

        // Forced revoke after MAXH cycles, then requester 3 wins under the rotated pointer.
        do_reset("reset_timeout");
        for (int i = 0; i < MAXH; i++) begin
            step("to.hold", 4'b0010, 4'b0000);
            check("to.gnt", 32'(ifc.gnt), 32'h2);
        end
        step("to.revoke", 4'b0010, 4'b0000);
        check("to.pulse", 32'(ifc.timeout), 32'd1);
        step("to.next", 4'b1010, 4'b0000);
        check("to.next_id", 32'(ifc.gnt_id), 32'd3);
        check("to.pulse_end", 32'(ifc.timeout), 32'd0);
        step("to.drop", 4'b0000, 4'b0000);

        // Release on the last allowed cycle wins over the hold limit.
        step("col.g1", 4'b0001, 4'b0000);
        for (int i = 1; i < MAXH; i++) step("col.hold", 4'b0001, 4'b0000);
        step("col.rel", 4'b0001, 4'b0001);
        check("col.no_timeout", 32'(ifc.timeout), 32'd0);
        check("col.gnt", 32'(ifc.gnt), 32'd0);

        // Non-owner rel and req changes are ignored while owned.
        do_reset("reset_ignore");
        step("ign.grant", 4'b0001, 4'b0000);
        step("ign.a", 4'b1001, 4'b0010);
        step("ign.b", 4'b0001, 4'b0010);
        check("ign.owner", 32'(ifc.gnt), 32'h1);
        step("ign.rel", 4'b1001, 4'b0001);
        step("ign.next", 4'b1000, 4'b0000);
        check("ign.next_id", 32'(ifc.gnt_id), 32'd3);
        step("ign.drop", 4'b0000, 4'b0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 4) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
            step("rand", r, l);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Round-robin arbiter that shares one resource among four requesters. A 2-bit rotating priority pointer, a 2-bit up-counter that wraps 3→0, sets the search order. The arbiter grants one owner at a time, holds the grant until the owner releases it, and revokes it after a bounded hold time. It sits in front of a shared counter or datapath and drives that resource's select and enable from `gnt` and `gnt_id`.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant may stay asserted. Legal range is 1..255; the internal hold counter is 8 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset). The clock is `clk`; the reset port is `reset`.
- `req`  in  4  per-requester request level.
- `rel`  in  4  per-requester release strobe. Sampled only for the current owner.
- `gnt`  out  4  one-hot grant, registered. All zero when idle.
- `gnt_id`  out  2  index of the current owner; holds the last owner while idle.
- `busy`  out  1  high while a grant is active; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- **Reset values:** state=IDLE, `gnt`=0000, `gnt_id`=00, `busy`=0, `timeout`=0, pointer `ptr`=00, hold count=0. Reset takes effect immediately, with no clock edge needed.
- **States:** IDLE and OWNED.
- **IDLE:**
  - If `req`≠0 at a clock edge, the winner is the first set bit in the order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4.
  - On that edge: `gnt`[winner]=1, `gnt_id`=winner, `ptr`=winner+1 (mod 4, so 3 wraps to 0), hold count=1, state goes to OWNED.
  - If `req`=0, nothing changes.
- **OWNED, exit conditions** (checked at each edge, in this priority):
  1. `rel`[owner]=1 or `req`[owner]=0: normal release, go to IDLE, `gnt`=0, `timeout`=0.
  2. Hold count = `MAX_HOLD`: forced revoke, go to IDLE, `gnt`=0, `timeout`=1 for exactly one cycle.
  3. Otherwise: hold count increments and the grant stays.
- `rel` bits of non-owners are ignored. `req` changes of non-owners are ignored while OWNED; they are evaluated at the first IDLE edge.
- **Simultaneous events:**
  - A release and a hold-limit condition at the same edge count as a normal release; no `timeout`.
  - An owner that re-requests after a revoke competes under the rotated pointer. It has lowest priority if others are requesting.
- `gnt` is always one-hot or zero. `gnt_id` is updated only when a new grant is issued.
- **Reset during OWNED:** `gnt` drops at once, `ptr` returns to 00, and any pending `timeout` is cleared.

## Timing
- **Grant latency:** `req` high before edge E0 in IDLE gives `gnt` high after E0. The minimum is 1 cycle.
- **Release latency:** `rel` sampled at edge E gives `gnt` low after E. The owner keeps the resource through the cycle in which it asserts `rel`.
- **Turnaround:** at least one cycle with `gnt`=0000 between consecutive grants, which is the IDLE cycle. Maximum throughput is one grant per 2 cycles for 1-cycle holds.
- **Hold limit:** `gnt` is high for at most `MAX_HOLD` consecutive cycles. With `MAX_HOLD`=1, every grant lasts exactly 1 cycle unless it is released earlier.
- **Timeout pulse:** `timeout` is high during the first `gnt`=0 cycle after a forced revoke, and low otherwise.
- **Fairness:** any requester holding `req` continuously is granted within 3 other grants.

## Test plan
- **Reset:** assert `reset`=0 mid-simulation → `gnt`=0000, `gnt_id`=00, `busy`=0, `timeout`=0, all without a clock edge. Release `reset` with `req`=0 → outputs stay 0.
- **Single requester:** `req`=0100 held, `rel`[2] pulsed on the 3rd grant cycle → `gnt`=0100 one cycle after `req`, `gnt_id`=10, `busy`=1 for 3 cycles, then `gnt`=0000. Next grant to requester 2 follows one IDLE cycle later.
- **Full contention:** `req`=1111 constant, each owner pulses `rel` on its first cycle → grant order 0,1,2,3,0,1. This checks `ptr` wrap 3→0; there is a 0000 gap cycle between each grant.
- **Timeout:** `MAX_HOLD`=4, `req`=0010 held, `rel`=0 → `gnt`=0010 for exactly 4 cycles, then `gnt`=0000 with `timeout`=1 for one cycle. With `req`=1010, the next grant goes to requester 3.
- **Collision:** `MAX_HOLD`=4, owner asserts `rel` on its 4th grant cycle → `gnt` drops and `timeout` stays 0.
- **Ignored inputs:** while requester 0 owns, pulse `rel`=0010 and toggle `req`[3] → the grant is unaffected. After requester 0 releases, `req`[3] is granted at the first IDLE edge if it is high.
